// File: rtl/digit_entry_buffer.sv
// Digit-entry register for the calculator front end: edge-detected digit entry,
// backspace, clear, decimal/hex filtering, ALU result loading and display blanking.
module digit_entry_buffer #(
    parameter int NDIG = 10,
    parameter int DW   = 4,
    parameter int CW   = $clog2(NDIG + 1)
) (
    input  logic                 CLK82MHZ,
    input  logic                 reset_n,
    input  logic                 enter,
    input  logic [DW-1:0]        num,
    input  logic                 digit_sel,
    input  logic                 backspace,
    input  logic                 clear,
    input  logic                 dec_mode,
    input  logic                 load,
    input  logic [NDIG*DW-1:0]   load_value,
    output logic [NDIG*DW-1:0]   mostrar,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 reject,
    output logic [NDIG-1:0]      blank
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    logic                r_enter_q;
    logic                r_bs_q;
    logic [1:0]          r_state;
    logic [NDIG*DW-1:0]  r_mostrar;
    logic [CW-1:0]       r_count;
    logic                r_reject;

    logic                w_enter_edge;
    logic                w_bs_edge;
    logic [CW-1:0]       w_load_count;
    logic [1:0]          w_state_next;
    logic [NDIG*DW-1:0]  w_mostrar_next;
    logic [CW-1:0]       w_count_next;
    logic                w_reject_next;

    assign w_enter_edge = enter & ~r_enter_q & digit_sel;
    assign w_bs_edge    = backspace & ~r_bs_q;

    // Significant digits of a loaded result: position of the highest nonzero digit + 1.
    always_comb begin
        w_load_count = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (load_value[i*DW +: DW] != '0) begin
                w_load_count = CW'(i + 1);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_mostrar_next = r_mostrar;
        w_count_next   = r_count;
        w_reject_next  = 1'b0;
        if (clear) begin
            w_state_next   = ST_EMPTY;
            w_mostrar_next = '0;
            w_count_next   = '0;
        end else if (load) begin
            w_state_next   = ST_RESULT;
            w_mostrar_next = load_value;
            w_count_next   = w_load_count;
        end else if (w_enter_edge) begin
            if (dec_mode && (num > DW'(9))) begin
                w_reject_next = 1'b1;
            end else if (r_state != ST_ENTRY) begin
                // A result on display is discarded, so both cases start from an empty register.
                if (num == '0) begin
                    w_state_next   = ST_EMPTY;
                    w_mostrar_next = '0;
                    w_count_next   = '0;
                end else begin
                    w_state_next   = ST_ENTRY;
                    w_mostrar_next = {{((NDIG-1)*DW){1'b0}}, num};
                    w_count_next   = CW'(1);
                end
            end else if (r_count == NDIG_C) begin
                w_reject_next = 1'b1;
            end else begin
                w_state_next   = ST_ENTRY;
                w_mostrar_next = {r_mostrar[NDIG*DW-DW-1:0], num};
                w_count_next   = r_count + CW'(1);
            end
        end else if (w_bs_edge) begin
            if (r_state == ST_ENTRY) begin
                w_mostrar_next = {{DW{1'b0}}, r_mostrar[NDIG*DW-1:DW]};
                w_count_next   = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_next = ST_EMPTY;
                end
            end else if (r_state == ST_RESULT) begin
                w_state_next   = ST_EMPTY;
                w_mostrar_next = '0;
                w_count_next   = '0;
            end
        end
    end

    always_ff @(posedge CLK82MHZ) begin
        if (!reset_n) begin
            r_enter_q <= 1'b1;
            r_bs_q    <= 1'b1;
            r_state   <= ST_EMPTY;
            r_mostrar <= '0;
            r_count   <= '0;
            r_reject  <= 1'b0;
        end else begin
            r_enter_q <= enter;
            r_bs_q    <= backspace;
            r_state   <= w_state_next;
            r_mostrar <= w_mostrar_next;
            r_count   <= w_count_next;
            r_reject  <= w_reject_next;
        end
    end

    assign mostrar = r_mostrar;
    assign count   = r_count;
    assign reject  = r_reject;
    assign full    = (r_state == ST_ENTRY) && (r_count == NDIG_C);

    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NDIG; gi++) begin : g_blank
            assign blank[gi] = (r_count <= CW'(gi));
        end
    endgenerate

endmodule
